// File: rtl/mlp_pkg.sv
// Shared types and sizes for the MLP result path.
package mlp_pkg;

    localparam int XDepth     = 256;
    localparam int XDataWidth = 8;

    typedef enum logic [1:0] {
        Idle,
        Read,
        Drain
    } reader_state_t;

endpackage

// File: rtl/mlp_skid_buf.sv
// Two-entry FIFO holding x memory read data until the host accepts it.
module mlp_skid_buf #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mlp_result_reader.sv
// Streams the final x memory activation vector to the host over valid/ready.
// Optional MLP_READER_OVERRUN_EN adds a sticky overrun_o flag.
module mlp_result_reader
    import mlp_pkg::*;
#(
    parameter  int DataWidth = XDataWidth,
    parameter  int Depth     = XDepth,
    localparam int AW        = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 result_valid_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 x_ren_o,
    output logic [AW-1:0]        x_addr_o,
    input  logic [DataWidth-1:0] x_rdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_last_o
`ifdef MLP_READER_OVERRUN_EN
    ,
    output logic                 overrun_o
`endif
);

    reader_state_t        state_q, state_d;
    logic [AW-1:0]        addr_q;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic                 done_q;
    logic [1:0]           buf_count;
    logic [DataWidth:0]   buf_head;
    logic                 room;
    logic                 issue;
    logic                 last_issue;
    logic                 handshake;
    logic                 buf_push;
    logic                 buf_pop;
    logic                 head_last;
    logic [DataWidth-1:0] head_data;

    // Buffered entries plus the read in flight may never exceed two.
    assign room       = (buf_count == 2'd0) || ((buf_count == 2'd1) && !inflight_q);
    assign issue      = (state_q == Read) && room;
    assign last_issue = issue && (addr_q == AW'(Depth - 1));

    // An empty buffer lets the arriving read word straight through to the host.
    always_comb begin
        head_data = '0;
        head_last = 1'b0;
        if (buf_count != 2'd0) begin
            {head_last, head_data} = buf_head;
        end else if (inflight_q) begin
            head_data = x_rdata_i;
            head_last = inflight_last_q;
        end
    end

    assign out_valid_o = (buf_count != 2'd0) || inflight_q;
    assign handshake   = out_valid_o && out_ready_i;
    assign buf_pop     = handshake && (buf_count != 2'd0);
    assign buf_push    = inflight_q && !(handshake && (buf_count == 2'd0));

    mlp_skid_buf #(
        .Width (DataWidth + 1)
    ) u_skid_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .data_i  ({inflight_last_q, x_rdata_i}),
        .data_o  (buf_head),
        .count_o (buf_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Idle:    if (result_valid_i)         state_d = Read;
            Read:    if (last_issue)             state_d = Drain;
            Drain:   if (handshake && head_last) state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= Idle;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            done_q          <= (state_q == Drain) && handshake && head_last;
            // The final read returns the counter to zero instead of wrapping past Depth.
            if (state_q == Idle) begin
                addr_q <= '0;
            end else if (issue) begin
                addr_q <= last_issue ? '0 : addr_q + AW'(1);
            end
        end
    end

`ifdef MLP_READER_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overrun_q <= 1'b0;
        end else if (result_valid_i && busy_o) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_o = overrun_q;
`endif

    assign busy_o     = (state_q != Idle);
    assign done_o     = done_q;
    assign x_ren_o    = issue;
    assign x_addr_o   = addr_q;
    assign out_data_o = head_data;
    assign out_last_o = head_last;

endmodule
